// File: rtl/seq_divider.sv
// seq_divider: multicycle restoring divider for DIV/DIVU.
// One quotient bit per clock, WIDTH+2 cycles from accepted start to done.
// Optional build macro SEQ_DIVIDER_ZERO_FAST_EN: a zero divisor skips the
// iteration phase and finishes two cycles after start with the same results.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] q;         // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0] rem;       // partial remainder; its top bit is always zero between
                                // iterations, so only WIDTH bits are stored
   logic [WIDTH-1:0] dsr_mag;
   logic [WIDTH-1:0] dvd_orig;  // raw dividend, returned as remainder on divide by zero
   logic             neg_q;
   logic             neg_r;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] dvd_abs;
   logic [WIDTH-1:0] dsr_abs;
   logic [WIDTH-1:0] shl_low;   // low WIDTH bits of the shifted partial remainder
   logic [WIDTH:0]   diff;      // WIDTH+1-bit trial subtraction

   // Operand magnitudes and the trial subtraction for the current iteration.
   // NOTE: combinational logic uses blocking '=' with every output assigned
   // first, so no latch is inferred; state below uses non-blocking '<='.
   always_comb begin
      dvd_abs = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
      dsr_abs = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
      shl_low = {rem[WIDTH-2:0], q[WIDTH-1]};
      diff    = {rem, q[WIDTH-1]} - {1'b0, dsr_mag};
   end

   // Control FSM with registered outputs and the iteration datapath.
   // NOTE: only control state and visible outputs are reset; the datapath
   // registers are always loaded on start before they are read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  q        <= dvd_abs;
                  dsr_mag  <= dsr_abs;
                  dvd_orig <= dividend;
                  rem      <= '0;
                  cnt      <= '0;
                  neg_q    <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  neg_r    <= sign & dividend[WIDTH-1];
                  div_zero <= (divisor == '0);
                  busy     <= 1'b1;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
                  state    <= (divisor == '0) ? FIX : CALC;
`else
                  state    <= CALC;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               // A negative trial result (top bit set) means restore.
               q   <= {q[WIDTH-2:0], ~diff[WIDTH]};
               rem <= diff[WIDTH] ? shl_low : diff[WIDTH-1:0];
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               if (div_zero) begin
                  quotient  <= '1;
                  remainder <= dvd_orig;
               end else begin
                  quotient  <= neg_q ? -q   : q;
                  remainder <= neg_r ? -rem : rem;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
